tlb_cam: RTL and testbench

Parametrised, fully associative MIPS32-style translation lookaside buffer for the pipelined CPU. It serves two independent translation ports, one for instruction fetch and one for data memory access, each with one-cycle registered latency. It also executes the CP0 TLB instructions TLBR, TLBWI, TLBWR and TLBP, and maintains the Random register. The block sits between the IF/MEM stages and the cache/memory interface; CP0 drives its management side.

---
 rtl/tlb_pkg.sv | 36 +++
 rtl/tlb_match.sv | 30 +++
 rtl/tlb_cam.sv | 187 ++++++++++++++++++
 tb/tb_tlb_cam.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared widths, op encoding and entry layout for the MIPS32-style TLB.
// EntryLo word layout is {PFN, C[2:0], D, V, G}; EntryHi is {VPN2, ASID}.
package tlb_pkg;

    localparam int VPN2_W = 19;
    localparam int PFN_W  = 20;
    localparam int ASID_W = 8;

    localparam int LO_G       = 0;
    localparam int LO_V       = 1;
    localparam int LO_D       = 2;
    localparam int LO_C_LSB   = 3;
    localparam int LO_PFN_LSB = 6;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'b00,
        OP_TLBWI = 2'b01,
        OP_TLBWR = 2'b10,
        OP_TLBP  = 2'b11
    } tlb_op_e;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } tlb_page_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        tlb_page_t [1:0]   pg;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational comparator array with lowest-index priority encoder.
// Only entries written since reset (i_used) can match.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic [ENTRIES-1:0] i_used,
    input  tlb_entry_t         i_ent [ENTRIES],
    input  logic [VPN2_W-1:0]  i_vpn2,
    input  logic [ASID_W-1:0]  i_asid,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_idx
);

    // Scanning downwards lets the lowest matching index overwrite the rest.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (i_used[k] && (i_ent[k].vpn2 == i_vpn2) &&
                (i_ent[k].g || (i_ent[k].asid == i_asid))) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/tlb_cam.sv
// Fully associative TLB with independent I/D translation ports, CP0
// management ops (TLBR/TLBWI/TLBWR/TLBP) and the Random register.
module tlb_cam
#(
    parameter int ENTRIES = 16,
    parameter int ASID_W  = tlb_pkg::ASID_W,
    parameter int PFN_W   = tlb_pkg::PFN_W,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [31:0]              i_vaddr,
    input  logic                     d_req,
    input  logic [31:0]              d_vaddr,
    input  logic                     d_store,
    output logic [PFN_W+11:0]        i_paddr,
    output logic                     i_miss,
    output logic                     i_invalid,
    output logic [PFN_W+11:0]        d_paddr,
    output logic                     d_miss,
    output logic                     d_invalid,
    output logic                     d_modified,
    input  logic [ASID_W-1:0]        asid,
    input  logic [1:0]               op,
    input  logic                     op_valid,
    input  logic [IDX_W-1:0]         index,
    input  logic [18+ASID_W:0]       entryhi_in,
    input  logic [PFN_W+5:0]         entrylo0_in,
    input  logic [PFN_W+5:0]         entrylo1_in,
    input  logic [IDX_W-1:0]         wired,
    input  logic                     wired_we,
    output logic [18+ASID_W:0]       rd_entryhi,
    output logic [PFN_W+5:0]         rd_entrylo0,
    output logic [PFN_W+5:0]         rd_entrylo1,
    output logic [IDX_W-1:0]         probe_index,
    output logic                     probe_miss,
    output logic                     op_done,
    output logic [IDX_W-1:0]         random
);
    import tlb_pkg::*;

    localparam int PA_W = PFN_W + 12;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    typedef struct packed {
        logic [PA_W-1:0] paddr;
        logic            miss;
        logic            inv;
        logic            modf;
    } look_t;

    tlb_entry_t         r_ent [ENTRIES];
    logic [ENTRIES-1:0] r_used;
    look_t              r_i, r_d;
    logic [18+ASID_W:0] r_rd_hi;
    logic [PFN_W+5:0]   r_rd_lo0, r_rd_lo1;
    logic [IDX_W-1:0]   r_probe_idx, r_random;
    logic               r_probe_miss, r_op_done;

    logic               w_i_hit, w_d_hit, w_p_hit;
    logic [IDX_W-1:0]   w_i_idx, w_d_idx, w_p_idx, w_wr_idx, w_random_nxt;
    tlb_op_e            w_op;
    logic               w_wr_en;
    tlb_entry_t         w_new, w_rd_ent;
    tlb_page_t          w_i_pg, w_d_pg;

    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_match_i (
        .i_used(r_used), .i_ent(r_ent), .i_vpn2(i_vaddr[31:13]), .i_asid(asid),
        .o_hit(w_i_hit), .o_idx(w_i_idx)
    );
    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_match_d (
        .i_used(r_used), .i_ent(r_ent), .i_vpn2(d_vaddr[31:13]), .i_asid(asid),
        .o_hit(w_d_hit), .o_idx(w_d_idx)
    );
    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_match_p (
        .i_used(r_used), .i_ent(r_ent),
        .i_vpn2(entryhi_in[ASID_W +: VPN2_W]), .i_asid(entryhi_in[ASID_W-1:0]),
        .o_hit(w_p_hit), .o_idx(w_p_idx)
    );

    // Flag priority is miss > invalid > modified; kseg0/kseg1 bypass the TLB.
    function automatic look_t lookup(input logic [31:0] va, input logic hit,
                                     input tlb_page_t pg, input logic st);
        look_t res;
        res = '0;
        if (va[31:30] == 2'b10) begin
            res.paddr = PA_W'(va & 32'h1FFF_FFFF);
        end else if (!hit) begin
            res.miss = 1'b1;
        end else if (!pg.v) begin
            res.inv = 1'b1;
        end else begin
            res.modf  = st & ~pg.d;
            res.paddr = {pg.pfn, va[11:0]};
        end
        return res;
    endfunction

    assign w_i_pg   = r_ent[w_i_idx].pg[i_vaddr[12]];
    assign w_d_pg   = r_ent[d_vaddr[12] ? w_d_idx : w_d_idx].pg[d_vaddr[12]];
    assign w_op     = tlb_op_e'(op);
    assign w_wr_en  = op_valid && ((w_op == OP_TLBWI) || (w_op == OP_TLBWR));
    assign w_wr_idx = (w_op == OP_TLBWR) ? r_random : index;
    assign w_rd_ent = r_ent[index];

    always_comb begin
        w_new           = '0;
        w_new.vpn2      = entryhi_in[ASID_W +: VPN2_W];
        w_new.asid      = entryhi_in[ASID_W-1:0];
        w_new.g         = entrylo0_in[LO_G] & entrylo1_in[LO_G];
        w_new.pg[0].pfn = entrylo0_in[LO_PFN_LSB +: PFN_W];
        w_new.pg[0].c   = entrylo0_in[LO_C_LSB +: 3];
        w_new.pg[0].d   = entrylo0_in[LO_D];
        w_new.pg[0].v   = entrylo0_in[LO_V];
        w_new.pg[1].pfn = entrylo1_in[LO_PFN_LSB +: PFN_W];
        w_new.pg[1].c   = entrylo1_in[LO_C_LSB +: 3];
        w_new.pg[1].d   = entrylo1_in[LO_D];
        w_new.pg[1].v   = entrylo1_in[LO_V];
    end

    always_comb begin
        w_random_nxt = r_random - 1'b1;
        if (wired_we || (wired >= LAST) || (r_random == wired)) begin
            w_random_nxt = LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                r_ent[k] <= '0;
            end
            r_used <= '0;
        end else if (w_wr_en) begin
            r_ent[w_wr_idx]  <= w_new;
            r_used[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i          <= '0;
            r_d          <= '0;
            r_rd_hi      <= '0;
            r_rd_lo0     <= '0;
            r_rd_lo1     <= '0;
            r_probe_idx  <= '0;
            r_probe_miss <= 1'b0;
            r_op_done    <= 1'b0;
            r_random     <= LAST;
        end else begin
            if (i_req) r_i <= lookup(i_vaddr, w_i_hit, w_i_pg, 1'b0);
            if (d_req) r_d <= lookup(d_vaddr, w_d_hit, w_d_pg, d_store);
            r_op_done <= op_valid;
            r_random  <= w_random_nxt;
            if (op_valid && (w_op == OP_TLBR)) begin
                r_rd_hi  <= {w_rd_ent.vpn2, w_rd_ent.asid};
                r_rd_lo0 <= {w_rd_ent.pg[0].pfn, w_rd_ent.pg[0].c, w_rd_ent.pg[0].d,
                             w_rd_ent.pg[0].v, w_rd_ent.g};
                r_rd_lo1 <= {w_rd_ent.pg[1].pfn, w_rd_ent.pg[1].c, w_rd_ent.pg[1].d,
                             w_rd_ent.pg[1].v, w_rd_ent.g};
            end
            if (op_valid && (w_op == OP_TLBP)) begin
                r_probe_idx  <= w_p_idx;
                r_probe_miss <= ~w_p_hit;
            end
        end
    end

    assign i_paddr     = r_i.paddr;
    assign i_miss      = r_i.miss;
    assign i_invalid   = r_i.inv;
    assign d_paddr     = r_d.paddr;
    assign d_miss      = r_d.miss;
    assign d_invalid   = r_d.inv;
    assign d_modified  = r_d.modf;
    assign rd_entryhi  = r_rd_hi;
    assign rd_entrylo0 = r_rd_lo0;
    assign rd_entrylo1 = r_rd_lo1;
    assign probe_index = r_probe_idx;
    assign probe_miss  = r_probe_miss;
    assign random      = r_random;
    // A reset arriving while the completion is pending suppresses the pulse.
    assign op_done     = r_op_done & ~rst;

endmodule

// File: tb/tb_tlb_cam.sv
// Bench for tlb_cam: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array-based model.
module tb_tlb_cam;

    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_store, op_valid, wired_we;
    logic [31:0] i_vaddr, d_vaddr;
    logic [7:0]  asid;
    logic [1:0]  op;
    logic [3:0]  index, wired;
    logic [26:0] entryhi_in;
    logic [25:0] entrylo0_in, entrylo1_in;
    logic [31:0] i_paddr, d_paddr;
    logic        i_miss, d_miss, i_invalid, d_invalid, d_modified;
    logic [26:0] rd_entryhi;
    logic [25:0] rd_entrylo0, rd_entrylo1;
    logic [3:0]  probe_index, random;
    logic        probe_miss, op_done;

    int n_cmp = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    tlb_cam dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_vaddr(i_vaddr), .d_req(d_req), .d_vaddr(d_vaddr),
        .d_store(d_store),
        .i_paddr(i_paddr), .i_miss(i_miss), .i_invalid(i_invalid),
        .d_paddr(d_paddr), .d_miss(d_miss), .d_invalid(d_invalid),
        .d_modified(d_modified),
        .asid(asid), .op(op), .op_valid(op_valid), .index(index),
        .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
        .wired(wired), .wired_we(wired_we),
        .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
        .probe_index(probe_index), .probe_miss(probe_miss), .op_done(op_done),
        .random(random)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pa;
        bit          miss;
        bit          inv;
        bit          modf;
    } res_t;

    bit          m_init = 1'b0;
    bit          m_used [16];
    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    bit          m_g    [16];
    logic [19:0] m_pfn  [16][2];
    logic [2:0]  m_c    [16][2];
    bit          m_d    [16][2];
    bit          m_v    [16][2];

    res_t        exp_i, exp_d;
    logic [26:0] exp_hi;
    logic [25:0] exp_lo0, exp_lo1;
    logic [3:0]  exp_pidx, exp_rand;
    bit          exp_pmiss, exp_done;

    function automatic int model_find(input logic [18:0] vpn, input logic [7:0] a);
        for (int k = 0; k < 16; k++)
            if (m_used[k] && m_vpn2[k] == vpn && (m_g[k] || m_asid[k] == a)) return k;
        return -1;
    endfunction

    function automatic res_t model_lookup(input logic [31:0] va, input logic [7:0] a, input bit st);
        res_t r;
        int   h;
        int   s;
        r = '{pa: 32'h0, miss: 1'b0, inv: 1'b0, modf: 1'b0};
        if (va[31:30] == 2'b10) begin
            r.pa = va & 32'h1FFF_FFFF;
            return r;
        end
        h = model_find(va[31:13], a);
        s = va[12] ? 1 : 0;
        if (h < 0) r.miss = 1'b1;
        else begin
            if (!m_v[h][s]) r.inv = 1'b1;
            else if (st && !m_d[h][s]) r.modf = 1'b1;
            r.pa = {m_pfn[h][s], va[11:0]};
        end
        return r;
    endfunction

    function automatic logic [25:0] mk_lo(input logic [19:0] pfn, input logic [2:0] c,
                                          input bit d, input bit v, input bit g);
        return {pfn, c, d, v, g};
    endfunction

    always @(posedge clk) begin
        int w;
        int h;
        if (rst) begin
            m_init = 1'b1;
            for (int k = 0; k < 16; k++) begin
                m_used[k] = 0; m_vpn2[k] = 0; m_asid[k] = 0; m_g[k] = 0;
                for (int s = 0; s < 2; s++) begin
                    m_pfn[k][s] = 0; m_c[k][s] = 0; m_d[k][s] = 0; m_v[k][s] = 0;
                end
            end
            exp_i = '{pa: 32'h0, miss: 1'b0, inv: 1'b0, modf: 1'b0};
            exp_d = exp_i;
            exp_hi = 0; exp_lo0 = 0; exp_lo1 = 0;
            exp_pidx = 0; exp_pmiss = 0; exp_done = 0; exp_rand = 4'd15;
        end else begin
            if (i_req) exp_i = model_lookup(i_vaddr, asid, 1'b0);
            if (d_req) exp_d = model_lookup(d_vaddr, asid, d_store);
            if (op_valid) begin
                case (op)
                    2'd0: begin
                        exp_hi  = {m_vpn2[index], m_asid[index]};
                        exp_lo0 = mk_lo(m_pfn[index][0], m_c[index][0], m_d[index][0],
                                        m_v[index][0], m_g[index]);
                        exp_lo1 = mk_lo(m_pfn[index][1], m_c[index][1], m_d[index][1],
                                        m_v[index][1], m_g[index]);
                    end
                    2'd3: begin
                        h = model_find(entryhi_in[26:8], entryhi_in[7:0]);
                        exp_pmiss = (h < 0);
                        exp_pidx  = (h < 0) ? 4'd0 : 4'(h);
                    end
                    default: begin
                        w = (op == 2'd2) ? int'(exp_rand) : int'(index);
                        m_used[w] = 1;
                        m_vpn2[w] = entryhi_in[26:8];
                        m_asid[w] = entryhi_in[7:0];
                        m_g[w]    = entrylo0_in[0] & entrylo1_in[0];
                        m_pfn[w][0] = entrylo0_in[25:6]; m_c[w][0] = entrylo0_in[5:3];
                        m_d[w][0]   = entrylo0_in[2];    m_v[w][0] = entrylo0_in[1];
                        m_pfn[w][1] = entrylo1_in[25:6]; m_c[w][1] = entrylo1_in[5:3];
                        m_d[w][1]   = entrylo1_in[2];    m_v[w][1] = entrylo1_in[1];
                    end
                endcase
            end
            exp_done = op_valid;
            exp_rand = (wired_we || wired == 4'd15 || exp_rand == wired) ? 4'd15 : exp_rand - 4'd1;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (m_init) begin
                check("random", random, exp_rand);
                check("op_done", op_done, exp_done && !rst);
                check("i_miss", i_miss, exp_i.miss);
                check("i_invalid", i_invalid, exp_i.inv);
                if (!exp_i.miss && !exp_i.inv) check("i_paddr", i_paddr, exp_i.pa);
                check("d_miss", d_miss, exp_d.miss);
                check("d_invalid", d_invalid, exp_d.inv);
                check("d_modified", d_modified, exp_d.modf);
                if (!exp_d.miss && !exp_d.inv && !exp_d.modf) check("d_paddr", d_paddr, exp_d.pa);
                check("rd_entryhi", rd_entryhi, exp_hi);
                check("rd_entrylo0", rd_entrylo0, exp_lo0);
                check("rd_entrylo1", rd_entrylo1, exp_lo1);
                check("probe_miss", probe_miss, exp_pmiss);
                if (!exp_pmiss) check("probe_index", probe_index, exp_pidx);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tlb_op(input logic [1:0] o, input logic [3:0] idx, input logic [26:0] hi,
                          input logic [25:0] lo0, input logic [25:0] lo1);
        op = o; index = idx; entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("op_done_lit", op_done, 1);
    endtask

    task automatic i_lookup(input logic [31:0] va);
        i_req = 1'b1; i_vaddr = va;
        tick();
        i_req = 1'b0;
    endtask

    task automatic d_lookup(input logic [31:0] va, input bit st);
        d_req = 1'b1; d_vaddr = va; d_store = st;
        tick();
        d_req = 1'b0; d_store = 1'b0;
    endtask

    function automatic logic [31:0] rand_va();
        logic [18:0] pool [4];
        pool[0] = 19'h00200; pool[1] = 19'h00201; pool[2] = 19'h30000; pool[3] = 19'h7FFFF;
        if ($urandom_range(0, 9) == 0) return {2'b10, 30'($urandom)};
        return {pool[$urandom_range(0, 3)], 13'($urandom)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] v;
        rst = 1'b1; i_req = 0; d_req = 0; d_store = 0; op_valid = 0; wired_we = 0;
        i_vaddr = 0; d_vaddr = 0; asid = 0; op = 0; index = 0; wired = 0;
        entryhi_in = 0; entrylo0_in = 0; entrylo1_in = 0;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;
        check("reset_random", random, 15);
        check("reset_d_miss", d_miss, 0);
        check("reset_op_done", op_done, 0);

        d_lookup(32'h0040_1000, 0);
        check("empty_d_miss", d_miss, 1);

        asid = 8'd5;
        tlb_op(2'd1, 4'd3, {19'h00200, 8'd5}, mk_lo(20'h12345, 3'd0, 0, 1, 0), 26'h0);
        i_lookup(32'h0040_0ABC);
        check("hit_i_paddr", i_paddr, 32'h1234_5ABC);
        check("hit_i_miss", i_miss, 0);
        check("hit_i_invalid", i_invalid, 0);
        i_lookup(32'h0040_1000);
        check("odd_i_invalid", i_invalid, 1);

        d_lookup(32'h0040_0000, 1);
        check("store_d_modified", d_modified, 1);
        asid = 8'd6;
        d_lookup(32'h0040_0000, 1);
        check("asid_d_miss", d_miss, 1);
        tlb_op(2'd1, 4'd3, {19'h00200, 8'd5}, mk_lo(20'h12345, 3'd0, 0, 1, 1),
               mk_lo(20'h0, 3'd0, 0, 0, 1));
        d_lookup(32'h0040_0000, 0);
        check("global_d_miss", d_miss, 0);
        check("global_d_paddr", d_paddr, 32'h1234_5000);

        wired = 4'd4; wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check("wired_we_random", random, 15);
        v = 4'd15;
        for (int k = 0; k < 30; k++) begin
            v = (v == 4'd4) ? 4'd15 : v - 4'd1;
            exp_q.push_back(v);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            check("random_seq", random, exp_q.pop_front());
        end
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check("wired_we_again", random, 15);
        tlb_op(2'd2, 4'd0, {19'h30000, 8'd9}, mk_lo(20'h0BEEF, 3'd2, 1, 1, 0),
               mk_lo(20'h0CAFE, 3'd0, 1, 1, 0));
        tlb_op(2'd0, 4'd15, 27'h0, 26'h0, 26'h0);
        check("tlbwr_rd_hi", rd_entryhi, {19'h30000, 8'd9});
        check("tlbwr_rd_lo0", rd_entrylo0, mk_lo(20'h0BEEF, 3'd2, 1, 1, 0));
        check("tlbwr_rd_lo1", rd_entrylo1, mk_lo(20'h0CAFE, 3'd0, 1, 1, 0));

        tlb_op(2'd3, 4'd0, {19'h00200, 8'd6}, 26'h0, 26'h0);
        check("probe_idx3", probe_index, 3);
        check("probe_hit", probe_miss, 0);
        tlb_op(2'd1, 4'd7, {19'h00200, 8'd5}, mk_lo(20'h12345, 3'd0, 0, 1, 1),
               mk_lo(20'h0, 3'd0, 0, 0, 1));
        tlb_op(2'd3, 4'd0, {19'h00200, 8'd6}, 26'h0, 26'h0);
        check("probe_dup_idx", probe_index, 3);
        tlb_op(2'd3, 4'd0, {19'h7FFFF, 8'd6}, 26'h0, 26'h0);
        check("probe_nomatch", probe_miss, 1);

        i_lookup(32'h8000_1234);
        check("kseg0_paddr", i_paddr, 32'h0000_1234);
        check("kseg0_miss", i_miss, 0);

        i_req = 1'b1; i_vaddr = 32'h0040_0ABC;
        op = 2'd1; index = 4'd3; entryhi_in = {19'h00200, 8'd5};
        entrylo0_in = mk_lo(20'h0ABCD, 3'd0, 1, 1, 1); entrylo1_in = mk_lo(20'h0, 3'd0, 0, 0, 1);
        op_valid = 1'b1;
        tick();
        i_req = 1'b0; op_valid = 1'b0;
        check("same_edge_old", i_paddr, 32'h1234_5ABC);
        i_lookup(32'h0040_0ABC);
        check("after_write_new", i_paddr, 32'h0ABC_DABC);

        op = 2'd3; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_no_op_done", op_done, 0);
        tick();
        rst = 1'b0;
        check("rst_random", random, 15);
        d_lookup(32'h0040_0000, 0);
        check("rst_cleared_miss", d_miss, 1);

        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            asid        = 8'($urandom_range(5, 6));
            i_req       = 1'($urandom);
            i_vaddr     = rand_va();
            d_req       = 1'($urandom);
            d_vaddr     = rand_va();
            d_store     = 1'($urandom);
            op_valid    = ($urandom_range(0, 2) == 0);
            op          = 2'($urandom);
            index       = 4'($urandom);
            entryhi_in  = {rand_va() >> 13, 8'($urandom_range(5, 6))};
            entrylo0_in = 26'($urandom);
            entrylo1_in = 26'($urandom);
            wired_we    = ($urandom_range(0, 19) == 0);
            if (wired_we) wired = 4'($urandom);
            tick();
        end
        rst = 0; i_req = 0; d_req = 0; op_valid = 0; wired_we = 0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
